// File: rtl/mdsa_pkg.sv
// mdsa_pkg: shared MDSA dimensions, index widths and streamer state encoding.
package mdsa_pkg;
   localparam int N = 8;
   localparam int DW = 32;
   localparam int SEQ_W = $clog2(N * N);
   localparam int RC_W = $clog2(N);
   localparam logic IDLE_ENC = 1'b0;
   localparam logic STREAM_ENC = 1'b1;
   typedef enum logic {IDLE = IDLE_ENC, STREAM = STREAM_ENC} state_t;
endpackage

// File: rtl/mdsa_index_map.sv
// mdsa_index_map: maps a stream sequence index to a flat row-major element index.
module mdsa_index_map
   import mdsa_pkg::*;
#(
   parameter int N = mdsa_pkg::N,
   parameter bit SNAKE = 1'b1,
   localparam int SW = $clog2(N * N),
   localparam int CW = $clog2(N)
) (
   input  logic [SW-1:0] seq_i,
   output logic [SW-1:0] idx_o
);
   logic [CW-1:0] row, pos, col;
   assign row = CW'(seq_i / SW'(N));
   assign pos = CW'(seq_i % SW'(N));
   assign col = (SNAKE && row[0]) ? CW'(N - 1) - pos : pos;
   assign idx_o = SW'(row) * SW'(N) + SW'(col);
endmodule

// File: rtl/mdsa_result_streamer.sv
// mdsa_result_streamer: captures the sorter result matrix and streams it
// one element per valid/ready transfer in row-major or snake order.
module mdsa_result_streamer
   import mdsa_pkg::*;
#(
   parameter int N = mdsa_pkg::N,
   parameter int DW = mdsa_pkg::DW,
   parameter bit SNAKE = 1'b1,
   localparam int SW = $clog2(N * N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              output_enable,
   input  logic [N*N*DW-1:0] data_out,
   output logic [DW-1:0]     m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              overrun
);
   state_t state_q, state_d;
   logic [SW-1:0] seq_q, seq_d, idx;
   logic [N*N*DW-1:0] cap_q, cap_d;
   logic done_q, done_d, ovr_q, ovr_d, xfer, last;
   assign m_valid = state_q == STREAM;
   assign last = seq_q == SW'(N * N - 1);
   assign m_last = m_valid && last;
   assign xfer = en && m_valid && m_ready;
   assign busy = m_valid;
   assign done = done_q;
   assign overrun = ovr_q;
   mdsa_index_map #(.N(N), .SNAKE(SNAKE)) u_map (.seq_i(seq_q), .idx_o(idx));
   assign m_data = cap_q[idx*DW +: DW];
   always_comb begin
      state_d = state_q;
      seq_d = seq_q;
      cap_d = cap_q;
      done_d = 1'b0;
      ovr_d = ovr_q;
      if (state_q == IDLE) begin
         if (output_enable) begin
            cap_d = data_out;
            seq_d = '0;
            state_d = STREAM;
         end
      end else begin
         // a strobe while streaming is dropped; only the sticky flag records it
         if (output_enable) ovr_d = 1'b1;
         if (xfer && last) begin
            state_d = IDLE;
            done_d = 1'b1;
         end else if (xfer) begin
            seq_d = seq_q + 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         seq_q <= '0;
         cap_q <= '0;
         done_q <= 1'b0;
         ovr_q <= 1'b0;
      end else if (en) begin
         state_q <= state_d;
         seq_q <= seq_d;
         cap_q <= cap_d;
         done_q <= done_d;
         ovr_q <= ovr_d;
      end
   end
endmodule

// File: tb/tb_mdsa_result_streamer.sv
// tb_mdsa_result_streamer: drives a row-major and a snake instance in parallel
// and compares every beat against per-order element lists built from the matrix.
module tb_mdsa_result_streamer;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1, output_enable = 1'b0, m_ready = 1'b0;
   logic [2047:0] data_out = '0;
   logic [31:0] m_data0, m_data1;
   logic m_valid0, m_valid1, m_last0, m_last1, busy0, busy1, done0, done1, overrun0, overrun1;
   int passed = 0, total = 0, ncyc = 0;
   logic [31:0] mat [64];
   logic [31:0] e0 [$];
   logic [31:0] e1 [$];
   bit exp_ovr = 0;

   always #5 clk = ~clk;

   mdsa_result_streamer #(.SNAKE(1'b0)) u0 (
      .clk(clk), .rst(rst), .en(en), .output_enable(output_enable), .data_out(data_out),
      .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready), .m_last(m_last0),
      .busy(busy0), .done(done0), .overrun(overrun0));
   mdsa_result_streamer #(.SNAKE(1'b1)) u1 (
      .clk(clk), .rst(rst), .en(en), .output_enable(output_enable), .data_out(data_out),
      .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready), .m_last(m_last1),
      .busy(busy1), .done(done1), .overrun(overrun1));

   function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endfunction

   task automatic load();
      e0.delete();
      e1.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            e0.push_back(mat[r*8+c]);
            e1.push_back((r % 2 == 1) ? mat[r*8+7-c] : mat[r*8+c]);
         end
      for (int k = 0; k < 64; k++) data_out[k*32 +: 32] = mat[k];
   endtask

   task automatic fill_rand();
      for (int k = 0; k < 64; k++) mat[k] = $urandom;
   endtask

   task automatic capture();
      load();
      output_enable = 1'b1;
      @(negedge clk);
      output_enable = 1'b0;
      chk("cap_valid", m_valid0, 1);
      chk("cap_busy", busy0, 1);
   endtask

   task automatic stream(input bit rnd, input int oe_at, input int en_at, input int rst_at,
                         input bit oe_done, output int cyc);
      int idx = 0;
      bit oe_fired = 0, en_fired = 0;
      cyc = 0;
      while (idx < 64) begin
         if (cyc > 3000) begin
            chk("timeout", 0, 1);
            return;
         end
         chk("valid", m_valid0, 1);
         chk("valid_snake", m_valid1, 1);
         chk("data_row", m_data0, e0[idx]);
         chk("data_snake", m_data1, e1[idx]);
         chk("last", m_last0, 32'(idx == 63));
         chk("last_snake", m_last1, 32'(idx == 63));
         if (idx == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_ovr = 0;
            chk("rst_valid", m_valid0, 0);
            chk("rst_busy", busy0, 0);
            chk("rst_overrun", overrun0, 0);
            return;
         end
         if (idx == en_at && !en_fired) begin
            en_fired = 1;
            en = 1'b0;
            m_ready = 1'b1;
            repeat (5) begin
               @(negedge clk);
               cyc++;
               chk("hold_valid", m_valid0, 1);
               chk("hold_data", m_data0, e0[idx]);
               chk("hold_data_snake", m_data1, e1[idx]);
            end
            en = 1'b1;
            continue;
         end
         if (idx == oe_at && !oe_fired) begin
            oe_fired = 1;
            exp_ovr = 1;
            output_enable = 1'b1;
            data_out = ~data_out;
         end
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_ready) idx++;
         @(negedge clk);
         cyc++;
         output_enable = 1'b0;
      end
      chk("end_valid", m_valid0, 0);
      chk("end_busy", busy0, 0);
      chk("done_pulse", done0, 1);
      chk("done_pulse_snake", done1, 1);
      chk("overrun", overrun0, 32'(exp_ovr));
      if (oe_done) begin
         fill_rand();
         load();
         output_enable = 1'b1;
      end
      @(negedge clk);
      output_enable = 1'b0;
      chk("done_clear", done0, 0);
      if (oe_done) begin
         chk("b2b_valid", m_valid0, 1);
         chk("b2b_overrun", overrun0, 32'(exp_ovr));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_m_data", m_data0, 0);
      chk("rst_m_valid", m_valid0, 0);
      chk("rst_m_last", m_last0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk("rst_overrun", overrun0, 0);
      for (int k = 0; k < 64; k++) mat[k] = 32'(k + 100);
      capture();
      stream(0, -1, -1, -1, 0, ncyc);
      chk("drain_cycles", 32'(ncyc), 64);
      fill_rand();
      capture();
      stream(1, -1, -1, -1, 0, ncyc);
      fill_rand();
      capture();
      stream(0, 10, -1, -1, 1, ncyc);
      stream(1, -1, -1, -1, 0, ncyc);
      fill_rand();
      capture();
      stream(0, -1, 20, -1, 0, ncyc);
      fill_rand();
      capture();
      stream(0, -1, -1, 30, 0, ncyc);
      fill_rand();
      capture();
      stream(1, -1, -1, -1, 0, ncyc);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mdsa_result_streamer.md
Name: mdsa_result_streamer

Overview:
- Output-side companion to the MDSA sorter top level.
- Captures the sorter's 2048-bit flat matrix result when the sorter signals output_enable.
- Streams the captured matrix out one 32-bit element per transfer over a valid/ready interface, in row-major or snake (boustrophedon) order.
- Sits between the sorter's data_out/output_enable and any word-wide consumer (FIFO, bus bridge, UART packer).

Parameters:
- N, 8, matrix dimension (N x N elements).
- DW, 32, element width in bits.
- SNAKE, 1, 1 = odd rows are emitted right-to-left (shear-sort final order); 0 = plain row-major.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low, all state, counters and outputs hold.
- output_enable  input  1  sorter result-valid strobe; sampled only in IDLE.
- data_out  input  N*N*DW  sorter result; element k = data_out[k*DW +: DW], row r = k/N, col c = k%N.
- m_data  output  DW  current streamed element.
- m_valid  output  1  m_data is valid.
- m_ready  input  1  consumer accepts m_data.
- m_last  output  1  high with the final element (sequence index N*N-1).
- busy  output  1  capture register holds an unsent matrix.
- done  output  1  one-cycle pulse after the final element is accepted.
- overrun  output  1  sticky; set when output_enable arrives while busy.

Behaviour:
- Reset values: m_data=0, m_valid=0, m_last=0, busy=0, done=0, overrun=0, state=IDLE, seq index=0, capture register=0.
- Reset mid-stream aborts the stream with no further beats and clears overrun.
- All register updates are qualified by en. With en=0:
  - m_valid, m_data and m_last hold.
  - m_ready is ignored, so no transfer counts.
  - output_enable is ignored.
- States: IDLE, STREAM.
- IDLE:
  - If en & output_enable at edge t, capture data_out, set seq=0, set busy=1, go to STREAM.
  - m_valid=1 from cycle t+1, so latency is one cycle.
- STREAM:
  - m_valid=1.
  - m_data = element at map(seq): row r = seq/N, pos p = seq%N; col = (SNAKE && r odd) ? N-1-p : p; element k = r*N+col.
  - A transfer occurs when en & m_valid & m_ready. On a transfer with seq < N*N-1, seq increments.
  - On a transfer with seq = N*N-1 (m_last=1):
    - next cycle: m_valid=0, busy=0, done=1 for one cycle, state IDLE.
- AXI-style rules:
  - m_data and m_last are stable while m_valid & !m_ready.
  - m_valid never drops before the transfer.
  - m_ready may be high in IDLE without effect.
- Throughput: one element per cycle under continuous m_ready, so N*N cycles per matrix. A new capture is possible at the earliest in the cycle done is high.
- Capture on the done cycle: output_enable in the cycle done is high is a legal capture, and the state is already IDLE.
- Overrun: en & output_enable while in STREAM sets overrun=1 until rst. The new data is discarded and the current stream continues unaltered.
- Widths: seq is clog2(N*N) bits (6 for defaults). Row/col are clog2(N) bits. Sequence index arithmetic must not wrap before N*N-1 is detected.
- Capture register: N*N*DW flops, a single 2048-bit bank for defaults. The element mux is built from map(seq) and is combinational from registered state.

Decomposition:
- Shared package mdsa_pkg holds:
  - N and DW defaults.
  - SEQ_W = clog2(N*N) and RC_W = clog2(N).
  - State encoding localparams: IDLE=0, STREAM=1.
- One sub-module, mdsa_index_map: combinational seq -> flat element index, honouring SNAKE. It is reused by a future input-side loader.

Test Plan:
- Row-major drain: SNAKE=0, element k = k+100, output_enable for 1 cycle, m_ready=1 → m_valid rises the cycle after capture; 64 beats 100..163 on consecutive cycles; m_last on beat 63; done pulses one cycle after.
- Snake order: SNAKE=1, same data → beats 0-7 = 100..107, beats 8-15 = 115..108, beat 63 = 156 with m_last=1.
- Backpressure: random m_ready toggling (~50%) → m_data and m_valid stable while stalled; exactly 64 transfers in correct order; no duplicates or skips.
- Overrun and back-to-back:
  - Second output_enable at beat 10 → overrun=1 and stays set; stream continues with the original data.
  - output_enable on the done cycle → new matrix captured; overrun unaffected.
- Enable and reset:
  - en=0 for 5 cycles mid-stream with m_ready=1 → no transfers; outputs frozen.
  - rst at beat 30 → next cycle m_valid=0, busy=0, overrun=0.
  - Subsequent capture restarts at beat 0.
